// File: rtl/js_pkg.sv
// Shared Johnson-code constants, FSM state encoding and small helpers for the
// Johnson-counter decoder/checker.
package js_pkg;

  localparam int unsigned VAL_W  = 3;
  localparam int unsigned CODE_W = 4;

  // Eight-state Johnson sequence; bit [0] is the leftmost bit.
  localparam logic [0:CODE_W-1] S0 = 4'b0000;
  localparam logic [0:CODE_W-1] S1 = 4'b1000;
  localparam logic [0:CODE_W-1] S2 = 4'b1100;
  localparam logic [0:CODE_W-1] S3 = 4'b1110;
  localparam logic [0:CODE_W-1] S4 = 4'b1111;
  localparam logic [0:CODE_W-1] S5 = 4'b0111;
  localparam logic [0:CODE_W-1] S6 = 4'b0011;
  localparam logic [0:CODE_W-1] S7 = 4'b0001;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Successor in the count sequence; 7 wraps to 0.
  function automatic logic [VAL_W-1:0] next_val(input logic [VAL_W-1:0] v);
    return v + VAL_W'(1);
  endfunction

endpackage

// File: rtl/js_dec.sv
// Combinational Johnson-code decoder: 4-bit code to 3-bit count plus legal flag.
module js_dec
  import js_pkg::*;
(
  input  logic [0:CODE_W-1] d,
  output logic [VAL_W-1:0]  val_c,
  output logic              legal_c
);

  always_comb begin
    val_c   = '0;
    legal_c = 1'b1;
    case (d)
      S0:      val_c = 3'd0;
      S1:      val_c = 3'd1;
      S2:      val_c = 3'd2;
      S3:      val_c = 3'd3;
      S4:      val_c = 3'd4;
      S5:      val_c = 3'd5;
      S6:      val_c = 3'd6;
      S7:      val_c = 3'd7;
      default: legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/js_decoder_chk.sv
// Johnson-counter decoder and sequence checker: decodes each valid sample,
// locks onto a run of successor codes and flags sequence/code errors.
module js_decoder_chk
  import js_pkg::*;
#(
  parameter int unsigned LOCK_N = 3,
  parameter int unsigned MISS_N = 2,
  parameter int unsigned ERRW   = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              EN,
  input  logic [0:3]        D,
  output logic [2:0]        CNT,
  output logic              CODE_OK,
  output logic              LOCK,
  output logic              ERR,
  output logic [ERRW-1:0]   ERRCNT
);

  state_t             state;
  logic [VAL_W-1:0]   ref_val;
  logic [2:0]         match_cnt;
  logic [2:0]         miss_cnt;

  logic [VAL_W-1:0]   dec_val;
  logic               dec_legal;
  logic [VAL_W-1:0]   exp_val;
  logic               is_succ;
  logic               lock_hit;
  logic               miss_last;
  logic               err_sat;

  js_dec u_dec (
    .d       (D),
    .val_c   (dec_val),
    .legal_c (dec_legal)
  );

  // ref_val holds the last accepted (or, when locked, the last expected) value.
  assign exp_val   = next_val(ref_val);
  assign is_succ   = dec_legal && (dec_val == exp_val);
  assign lock_hit  = (match_cnt == 3'(LOCK_N));
  assign miss_last = ((miss_cnt + 3'd1) == 3'(MISS_N));
  assign err_sat   = (ERRCNT == {ERRW{1'b1}});

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state     <= HUNT;
      ref_val   <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      CNT       <= '0;
      CODE_OK   <= 1'b0;
      LOCK      <= 1'b0;
      ERR       <= 1'b0;
      ERRCNT    <= '0;
    end else begin
      ERR <= 1'b0;
      if (EN) begin
        CODE_OK <= dec_legal;
        if (dec_legal) begin
          CNT <= dec_val;
        end

        case (state)
          HUNT: begin
            if (dec_legal) begin
              ref_val   <= dec_val;
              match_cnt <= 3'd1;
              state     <= CONFIRM;
            end
          end

          CONFIRM: begin
            if (!dec_legal) begin
              match_cnt <= '0;
              state     <= HUNT;
            end else if (is_succ) begin
              ref_val <= dec_val;
              // match_cnt counts the whole run, so LOCK_N successors end at LOCK_N+1 codes.
              if (lock_hit) begin
                match_cnt <= '0;
                miss_cnt  <= '0;
                LOCK      <= 1'b1;
                state     <= LOCKED;
              end else begin
                match_cnt <= match_cnt + 3'd1;
              end
            end else begin
              ref_val   <= dec_val;
              match_cnt <= 3'd1;
            end
          end

          LOCKED: begin
            ref_val <= exp_val;
            if (is_succ) begin
              miss_cnt <= '0;
            end else begin
              ERR <= 1'b1;
              if (!err_sat) begin
                ERRCNT <= ERRCNT + ERRW'(1);
              end
              if (miss_last) begin
                miss_cnt  <= '0;
                match_cnt <= '0;
                LOCK      <= 1'b0;
                state     <= HUNT;
              end else begin
                miss_cnt <= miss_cnt + 3'd1;
              end
            end
          end

          default: begin
            LOCK  <= 1'b0;
            state <= HUNT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_js_decoder_chk.sv
// Self-checking bench for js_decoder_chk: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_js_decoder_chk;

  localparam int unsigned LOCK_N  = 3;
  localparam int unsigned MISS_N  = 2;
  localparam int unsigned ERRW    = 4;
  localparam int          ERR_MAX = (1 << ERRW) - 1;

  logic            clk = 1'b0;
  logic            clr = 1'b0;
  logic            en  = 1'b0;
  logic [0:3]      d   = 4'b0000;
  logic [2:0]      cnt;
  logic            code_ok;
  logic            lock;
  logic            err;
  logic [ERRW-1:0] errcnt;

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  // Model outputs and state
  int m_cnt, m_ok, m_lock, m_err, m_errcnt;
  bit m_locked;
  int m_chain;
  int m_last;
  int m_miss;

  js_decoder_chk #(
    .LOCK_N (LOCK_N),
    .MISS_N (MISS_N),
    .ERRW   (ERRW)
  ) dut (
    .CLK     (clk),
    .CLR     (clr),
    .EN      (en),
    .D       (d),
    .CNT     (cnt),
    .CODE_OK (code_ok),
    .LOCK    (lock),
    .ERR     (err),
    .ERRCNT  (errcnt)
  );

  always #5 clk = ~clk;

  function automatic logic [0:3] code_of(input int i);
    case (i)
      0:       return 4'b0000;
      1:       return 4'b1000;
      2:       return 4'b1100;
      3:       return 4'b1110;
      4:       return 4'b1111;
      5:       return 4'b0111;
      6:       return 4'b0011;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic int dec(input logic [0:3] x);
    for (int i = 0; i < 8; i++) begin
      if (code_of(i) == x) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // m_chain = length of the current run of successor codes (0 = no reference yet).
  task automatic model_step();
    int v;
    if (clr) begin
      m_cnt = 0; m_ok = 0; m_lock = 0; m_err = 0; m_errcnt = 0;
      m_locked = 1'b0; m_chain = 0; m_last = 0; m_miss = 0;
    end else begin
      m_err = 0;
      if (en) begin
        v    = dec(d);
        m_ok = (v >= 0) ? 1 : 0;
        if (v >= 0) m_cnt = v;
        if (!m_locked) begin
          if (v < 0) begin
            m_chain = 0;
          end else if (m_chain > 0 && v == (m_last + 1) % 8) begin
            m_chain++;
            m_last = v;
            if (m_chain - 1 >= int'(LOCK_N)) begin
              m_locked = 1'b1;
              m_miss   = 0;
            end
          end else begin
            m_chain = 1;
            m_last  = v;
          end
        end else begin
          m_last = (m_last + 1) % 8;
          if (v == m_last) begin
            m_miss = 0;
          end else begin
            m_err = 1;
            if (m_errcnt < ERR_MAX) m_errcnt++;
            m_miss++;
            if (m_miss == int'(MISS_N)) begin
              m_locked = 1'b0;
              m_chain  = 0;
              m_miss   = 0;
            end
          end
        end
        m_lock = m_locked ? 1 : 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Outputs are only driven from flops, so mid-cycle values are stable.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("model_cnt",     int'(cnt),     m_cnt);
      chk("model_code_ok", int'(code_ok), m_ok);
      chk("model_lock",    int'(lock),    m_lock);
      chk("model_err",     int'(err),     m_err);
      chk("model_errcnt",  int'(errcnt),  m_errcnt);
    end
  end

  task automatic step(input logic c, input logic e, input logic [0:3] x);
    @(negedge clk);
    clr = c;
    en  = e;
    d   = x;
    @(posedge clk);
    #1;
  endtask

  task automatic lock_from_reset();
    step(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, code_of(i));
  endtask

  int         idx;
  int         r;
  int         k;
  logic       rc;
  logic       re;
  logic [0:3] rx;

  initial begin
    // Reset state
    step(1'b1, 1'b1, 4'b1110);
    started = 1'b1;
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_code_ok", int'(code_ok), 0);
    chk("rst_lock", int'(lock), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_errcnt", int'(errcnt), 0);

    // Lock after three successors
    step(1'b0, 1'b1, code_of(0));
    chk("lock_s0_ok", int'(code_ok), 1);
    step(1'b0, 1'b1, code_of(1));
    step(1'b0, 1'b1, code_of(2));
    chk("lock_s2_nolock", int'(lock), 0);
    step(1'b0, 1'b1, code_of(3));
    chk("lock_s3_lock", int'(lock), 1);
    chk("lock_s3_cnt", int'(cnt), 3);
    chk("lock_s3_errcnt", int'(errcnt), 0);

    // Wrap 7 -> 0 while locked
    for (int i = 4; i < 8; i++) step(1'b0, 1'b1, code_of(i));
    step(1'b0, 1'b1, code_of(0));
    chk("wrap_cnt", int'(cnt), 0);
    chk("wrap_lock", int'(lock), 1);
    chk("wrap_errcnt", int'(errcnt), 0);

    // Illegal code then correct flywheel value
    step(1'b0, 1'b1, code_of(1));
    step(1'b0, 1'b1, code_of(2));
    step(1'b0, 1'b1, 4'b0101);
    chk("glitch_err", int'(err), 1);
    chk("glitch_ok", int'(code_ok), 0);
    chk("glitch_cnt", int'(cnt), 2);
    chk("glitch_lock", int'(lock), 1);
    step(1'b0, 1'b1, code_of(4));
    chk("recover_err", int'(err), 0);
    chk("recover_ok", int'(code_ok), 1);
    chk("recover_cnt", int'(cnt), 4);
    chk("recover_lock", int'(lock), 1);
    chk("recover_errcnt", int'(errcnt), 1);

    // Two wrong legal codes drop lock
    lock_from_reset();
    step(1'b0, 1'b1, code_of(0));
    chk("miss1_err", int'(err), 1);
    chk("miss1_lock", int'(lock), 1);
    step(1'b0, 1'b1, code_of(0));
    chk("miss2_err", int'(err), 1);
    chk("miss2_lock", int'(lock), 0);
    chk("miss2_errcnt", int'(errcnt), 2);
    step(1'b0, 1'b1, code_of(5));
    chk("hunt_no_err", int'(err), 0);
    chk("hunt_no_lock", int'(lock), 0);

    // EN gaps: lock timing counted in EN cycles, outputs hold
    step(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, code_of(i));
      step(1'b0, 1'b0, code_of(6));
      chk("gap_hold_cnt", int'(cnt), i);
      chk("gap_hold_lock", int'(lock), (i == 3) ? 1 : 0);
    end

    // CLR mid-lock with ERRCNT=5
    lock_from_reset();
    for (int i = 4; i < 13; i++) begin
      step(1'b0, 1'b1, (i % 2 == 0) ? 4'b0101 : code_of(i % 8));
    end
    chk("pre_clr_errcnt", int'(errcnt), 5);
    chk("pre_clr_lock", int'(lock), 1);
    step(1'b1, 1'b1, code_of(5));
    chk("clr_cnt", int'(cnt), 0);
    chk("clr_ok", int'(code_ok), 0);
    chk("clr_lock", int'(lock), 0);
    chk("clr_errcnt", int'(errcnt), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, code_of(i));
    chk("relock_wait", int'(lock), 0);
    step(1'b0, 1'b1, code_of(3));
    chk("relock", int'(lock), 1);

    // Error counter saturation
    step(1'b1, 1'b0, 4'b0000);
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, code_of(i));
      step(1'b0, 1'b1, code_of(0));
      step(1'b0, 1'b1, code_of(0));
    end
    chk("sat_errcnt", int'(errcnt), ERR_MAX);

    // Random mix of runs, glitches, EN gaps and rare resets
    idx = 0;
    for (int n = 0; n < 3000; n++) begin
      r  = int'($urandom_range(199));
      k  = int'($urandom_range(99));
      rc = (r == 0);
      re = ($urandom_range(3) != 0);
      if (k < 85)      rx = code_of(idx);
      else if (k < 93) rx = code_of(int'($urandom_range(7)));
      else             rx = 4'($urandom_range(15));
      step(rc, re, rx);
      if (re) idx = (idx + 1) % 8;
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/js_decoder_chk.md
JS_DECODER_CHK -- requirements
Module: js_decoder_chk

Interface
REQ-001 SHALL have parameter LOCK_N, default 3: consecutive legal successor codes needed to enter LOCKED (range 2..7).
REQ-002 SHALL have parameter MISS_N, default 2: consecutive mismatches in LOCKED that force HUNT (range 1..7).
REQ-003 SHALL have parameter ERRW, default 8: width of the error counter.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port CLR, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port EN, input, 1 bit: D is a valid sample this cycle.
REQ-007 SHALL have port D, input, [0:3]: 4-bit Johnson code from an 8-state Johnson counter; D[0] is the leftmost bit.
REQ-008 SHALL have port CNT, output, [2:0]: decoded binary count.
REQ-009 SHALL have port CODE_OK, output, 1 bit: the last sampled D was a legal code.
REQ-010 SHALL have port LOCK, output, 1 bit: FSM is in LOCKED.
REQ-011 SHALL have port ERR, output, 1 bit: one-cycle pulse on any sequence or code error.
REQ-012 SHALL have port ERRCNT, output, [ERRW-1:0]: saturating count of ERR pulses.

Function
REQ-013 SHALL decode 0000/1000/1100/1110/1111/0111/0011/0001 to 0..7; the other 8 codes are illegal.
REQ-014 SHALL register every output; CNT and CODE_OK update exactly 1 cycle after an EN cycle and hold when EN=0.
REQ-015 SHALL leave CNT unchanged and set CODE_OK=0 on an illegal sample.
REQ-016 SHALL implement FSM states HUNT, CONFIRM, LOCKED, evaluated only on EN=1 cycles.
REQ-017 In HUNT: a legal sample becomes the reference and the FSM moves to CONFIRM with match count 1; an illegal sample keeps HUNT with no ERR.
REQ-018 In CONFIRM: a sample equal to (reference+1) mod 8 increments the match count and becomes the reference; at match count LOCK_N the FSM moves to LOCKED.
REQ-019 In CONFIRM: a legal non-successor restarts with match count 1 on that code; an illegal sample returns to HUNT; neither case asserts ERR.
REQ-020 In LOCKED: the expected value advances by 1 mod 8 on every EN (flywheel), whether the sample matches or not.
REQ-021 In LOCKED: a match clears the miss count.
REQ-022 In LOCKED: a mismatch or illegal code pulses ERR and increments the miss count.
REQ-023 In LOCKED: at miss count MISS_N the FSM goes to HUNT and LOCK falls in the same cycle that ERR pulses.
REQ-024 SHALL treat wrap 0001->0000 (7->0) as a legal successor.
REQ-025 SHALL increment ERRCNT on every ERR, saturating at all-ones with no wrap.
REQ-026 LOCK and ERR SHALL be registered and asserted 1 cycle after the deciding EN sample.

Reset
REQ-027 CLR=1 at a rising edge SHALL force HUNT, CNT=0, CODE_OK=0, LOCK=0, ERR=0, ERRCNT=0, reference=0, and match and miss counts=0.
REQ-028 CLR SHALL override EN in the same cycle, including mid-LOCKED; the first sample after CLR falls is handled as in HUNT.

Structure
REQ-029 A shared package js_pkg SHALL hold the eight Johnson code constants S0..S7 (S0=0000 ... S7=0001) and the FSM state encoding.
REQ-030 Decoding SHALL live in one combinational sub-module js_dec (D -> 3-bit value + legal flag), instantiated once.

Verification
REQ-031 Reset then 0000,1000,1100,1110 with EN=1 every cycle -> LOCK=1 one cycle after the 3rd successor (1110); CNT=3; ERR never asserted.
REQ-032 Locked, feed 0001 then 0000 -> wrap accepted; CNT=0; LOCK stays 1; ERRCNT=0.
REQ-033 Locked at CNT=2, inject 0101 then the correct 1111 -> ERR pulses once; CODE_OK=0 then 1; CNT holds 2 then 4; LOCK stays 1; ERRCNT=1.
REQ-034 Locked, two consecutive wrong legal codes -> ERR pulses twice; LOCK=0 after the 2nd; FSM in HUNT; ERRCNT=2.
REQ-035 EN toggling 1,0,1,0 with a legal sequence -> identical lock timing counted in EN cycles; outputs hold on EN=0 cycles.
REQ-036 Assert CLR while LOCKED with ERRCNT=5 -> next cycle all outputs 0; relock requires LOCK_N fresh successors.
